// File: rtl/johnson_pkg.sv
// Shared types and Johnson-code helpers for the TDM arbiter.
//
// The helpers work on a fixed-width word (JS_MAX_W bits). The live stage
// count n is passed as an argument, and bits at and above n are ignored.
// Callers zero-extend their N-bit ring state before calling a helper.
package johnson_pkg;

    localparam int unsigned JS_MAX_W = 32;

    typedef logic [JS_MAX_W-1:0] js_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } arb_state_t;

    // One Johnson step: the inverted MSB feeds bit 0, and every other bit shifts up.
    function automatic js_word_t js_next(input js_word_t js, input int unsigned n);
        js_word_t r;
        r = '0;
        r[0] = ~js[n-1];
        for (int unsigned i = 1; i < n; i++) begin
            r[i] = js[i-1];
        end
        return r;
    endfunction

    // Slot number from the ring state.
    // While the ones are filling in from bit 0, the slot is the count of ones.
    // While the ones are draining out (MSB set), the slot is 2n minus that count.
    function automatic int unsigned js_to_slot(input js_word_t js, input int unsigned n);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < n; i++) begin
            if (js[i]) begin
                ones++;
            end
        end
        return js[n-1] ? (2 * n - ones) : ones;
    endfunction

    // A legal code holds one run of ones anchored at bit 0 or at bit n-1.
    // In both cases adjacent bits differ in at most one place.
    function automatic logic js_is_legal(input js_word_t js, input int unsigned n);
        int unsigned changes;
        changes = 0;
        for (int unsigned i = 0; i + 1 < n; i++) begin
            if (js[i] != js[i+1]) begin
                changes++;
            end
        end
        return (changes <= 1);
    endfunction

endpackage

// File: rtl/johnson_phase_gen.sv
// Johnson ring slot sequencer: N flops sequence 2N slots.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset (ring state goes to 0)
//   adv      - advance the ring by one slot this cycle
//   clr      - force the ring state to 0 at the next edge (recovery from an illegal code)
//   js       - raw ring state
//   slot_idx - decoded slot number, 0..2N-1
//   legal    - high when js is one of the 2N legal codes
module johnson_phase_gen
    import johnson_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    adv,
    input  logic                    clr,
    output logic [N-1:0]            js,
    output logic [$clog2(2*N)-1:0]  slot_idx,
    output logic                    legal
);

    localparam int unsigned SW = $clog2(2 * N);

    js_word_t js_ext;
    js_word_t js_nxt;
    logic     unused_js_hi;

    always_comb begin
        js_ext = '0;
        js_ext[N-1:0] = js;
    end

    assign js_nxt       = js_next(js_ext, N);
    assign unused_js_hi = ^js_nxt[JS_MAX_W-1:N];
    assign slot_idx     = SW'(js_to_slot(js_ext, N));
    assign legal        = js_is_legal(js_ext, N);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            js <= '0;
        end else if (adv) begin
            js <= js_nxt[N-1:0];
        end
    end

endmodule

// File: rtl/johnson_tdm_arbiter.sv
// Time-division arbiter that shares one resource among 2N requesters.
// Slots are visited in fixed order by an N-stage Johnson ring.
// The owner of the current slot is granted if it requests, and the grant
// is held for at most HOLD_MAX cycles before the ring advances.
//
// Optional build macro: JOHNSON_TDM_ILLEGAL_DET_EN.
//   Defined: an illegal ring code pulses `illegal`, clears the ring and drops any grant.
//   Undefined: `illegal` is always 0, and illegal codes shift like a plain Johnson counter.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   en        - arbiter enable
//   req       - request per slot owner; bit k belongs to slot k
//   gnt       - registered one-hot grant
//   gnt_valid - registered OR of gnt
//   slot_idx  - current slot index
//   phase     - raw Johnson ring state
//   wrap      - one-cycle pulse after the slot advances from 2N-1 to 0
//   illegal   - one-cycle pulse after an illegal ring code (macro builds only)
module johnson_tdm_arbiter
    import johnson_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [2*N-1:0]          req,
    output logic [2*N-1:0]          gnt,
    output logic                    gnt_valid,
    output logic [$clog2(2*N)-1:0]  slot_idx,
    output logic [N-1:0]            phase,
    output logic                    wrap,
    output logic                    illegal
);

    localparam int unsigned S  = 2 * N;
    localparam int unsigned SW = $clog2(S);
    localparam int unsigned HW = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_LIM  = HW'(HOLD_MAX);
    localparam logic [SW-1:0] LAST_SLOT = SW'(S - 1);

    arb_state_t    state, state_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [S-1:0]  gnt_n;
    logic [S-1:0]  slot_oh;
    logic          wrap_n;
    logic          illegal_n;
    logic          adv;
    logic          clr;
    logic          js_legal;

    johnson_phase_gen #(
        .N (N)
    ) u_phase (
        .clk      (clk),
        .rst      (rst),
        .adv      (adv),
        .clr      (clr),
        .js       (phase),
        .slot_idx (slot_idx),
        .legal    (js_legal)
    );

    always_comb begin
        slot_oh = '0;
        slot_oh[slot_idx] = 1'b1;
    end

    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        gnt_n     = gnt;
        adv       = 1'b0;
        clr       = 1'b0;
        illegal_n = 1'b0;
        unique case (state)
            IDLE: begin
                gnt_n  = '0;
                hold_n = '0;
                if (en) begin
                    state_n = SCAN;
                end
            end
            SCAN: begin
                gnt_n  = '0;
                hold_n = '0;
                if (!en) begin
                    state_n = IDLE;
                end else if (req[slot_idx]) begin
                    state_n = GRANT;
                    gnt_n   = slot_oh;
                    hold_n  = HW'(1);
                end else begin
                    adv = 1'b1;
                end
            end
            GRANT: begin
                // en is not checked while the grant is held; it only picks
                // the state that follows the release.
                if (req[slot_idx] && (hold_cnt < HOLD_LIM)) begin
                    hold_n = hold_cnt + HW'(1);
                end else begin
                    gnt_n  = '0;
                    hold_n = '0;
                    adv    = 1'b1;
                    if (en) begin
                        state_n = SCAN;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                gnt_n   = '0;
                hold_n  = '0;
                state_n = IDLE;
            end
        endcase
`ifdef JOHNSON_TDM_ILLEGAL_DET_EN
        // Recovery overrides all FSM activity for this cycle.
        if (!js_legal) begin
            illegal_n = 1'b1;
            clr       = 1'b1;
            adv       = 1'b0;
            gnt_n     = '0;
            hold_n    = '0;
            if (en) begin
                state_n = SCAN;
            end else begin
                state_n = IDLE;
            end
        end
`endif
    end

`ifndef JOHNSON_TDM_ILLEGAL_DET_EN
    logic unused_legal;
    assign unused_legal = js_legal;
`endif

    assign wrap_n = adv && (slot_idx == LAST_SLOT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            wrap      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            gnt_valid <= |gnt_n;
            hold_cnt  <= hold_n;
            wrap      <= wrap_n;
            illegal   <= illegal_n;
        end
    end

endmodule

// File: tb/tb_johnson_tdm_arbiter.sv
// Self-checking bench for johnson_tdm_arbiter (N=4, HOLD_MAX=4).
// Directed table vectors, hand-written multi-cycle sequences, then random
// stimulus compared against a slot-level reference model.
module tb_johnson_tdm_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned HOLD_MAX = 4;
    localparam int unsigned S        = 2 * N;
    localparam int unsigned SW       = $clog2(S);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [S-1:0]  req = '0;
    logic [S-1:0]  gnt;
    logic          gnt_valid;
    logic [SW-1:0] slot_idx;
    logic [N-1:0]  phase;
    logic          wrap;
    logic          illegal;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    johnson_tdm_arbiter #(
        .N        (N),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .slot_idx  (slot_idx),
        .phase     (phase),
        .wrap      (wrap),
        .illegal   (illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs at a falling edge, let one rising edge pass, and return
    // at the next falling edge so outputs are sampled away from the clock.
    task automatic step(input logic r, input logic e, input logic [S-1:0] q);
        rst = r;
        en  = e;
        req = q;
        @(negedge clk);
    endtask

    // Reference model: slot number, mode and hold count as plain integers.
    int           m_slot = 0;
    int           m_mode = 0;  // 0 idle, 1 scanning, 2 granting
    int           m_hold = 0;
    logic [S-1:0] m_gnt  = '0;
    logic         m_wrap = 1'b0;

    // Ring state for a slot: s low ones while filling (s <= N),
    // then all ones with the lowest (s-N) bits cleared.
    function automatic logic [N-1:0] slot_phase(input int s);
        int full;
        full = (1 << N) - 1;
        if (s <= N) return N'((1 << s) - 1);
        return N'(full ^ ((1 << (s - N)) - 1));
    endfunction

    task automatic model_advance();
        m_wrap = (m_slot == S - 1);
        m_slot = (m_slot + 1) % S;
    endtask

    task automatic model_step(input logic r, input logic e, input logic [S-1:0] q);
        m_wrap = 1'b0;
        if (r) begin
            m_slot = 0; m_mode = 0; m_hold = 0; m_gnt = '0;
        end else if (m_mode == 0) begin
            m_gnt = '0;
            if (e) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!e) begin
                m_mode = 0;
            end else if (q[m_slot]) begin
                m_mode = 2;
                m_hold = 1;
                m_gnt  = '0;
                m_gnt[m_slot] = 1'b1;
            end else begin
                model_advance();
            end
        end else begin
            if (q[m_slot] && m_hold < HOLD_MAX) begin
                m_hold++;
            end else begin
                m_gnt  = '0;
                m_hold = 0;
                m_mode = e ? 1 : 0;
                model_advance();
            end
        end
    endtask

    typedef struct {
        logic          r;
        logic          e;
        logic [S-1:0]  q;
        int            slot;
        logic [N-1:0]  ph;
        logic [S-1:0]  g;
        logic          w;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    initial begin
        int run;
        int gap;
        logic          rr;
        logic          ee;
        logic [S-1:0]  qq;

        // Reset, free scan over one full revolution, then a 2-cycle grant in slot 3.
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 0, 4'b0000, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h00, 0, 4'b0000, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h00, 1, 4'b0001, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h00, 2, 4'b0011, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, 3, 4'b0111, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h00, 4, 4'b1111, 8'h00, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h00, 5, 4'b1110, 8'h00, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h00, 6, 4'b1100, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8'h00, 7, 4'b1000, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 0, 4'b0000, 8'h00, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 1, 4'b0001, 8'h00, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h00, 2, 4'b0011, 8'h00, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 3, 4'b0111, 8'h00, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 8'h08, 3, 4'b0111, 8'h08, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 8'h08, 3, 4'b0111, 8'h08, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 8'h00, 4, 4'b1111, 8'h00, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 8'h00, 5, 4'b1110, 8'h00, 1'b0};

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].q);
            check($sformatf("tbl%0d_slot", i),    32'(slot_idx),  32'(tbl[i].slot));
            check($sformatf("tbl%0d_phase", i),   32'(phase),     32'(tbl[i].ph));
            check($sformatf("tbl%0d_gnt", i),     32'(gnt),       32'(tbl[i].g));
            check($sformatf("tbl%0d_gvalid", i),  32'(gnt_valid), 32'(tbl[i].g != '0));
            check($sformatf("tbl%0d_wrap", i),    32'(wrap),      32'(tbl[i].w));
            check($sformatf("tbl%0d_illegal", i), 32'(illegal),   32'h0);
        end

        // Hold limit: req[5] held permanently from the slot-5 scan cycle.
        run = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 8'h20);
            if (gnt != 8'h20) break;
            run++;
        end
        check("hold_len", 32'(run), 32'd4);
        check("hold_rel_slot", 32'(slot_idx), 32'd6);
        gap = 1;
        for (int i = 0; i < 40 && gnt != 8'h20; i++) begin
            step(1'b0, 1'b1, 8'h20);
            if (gnt != 8'h20) gap++;
        end
        check("regrant_gnt", 32'(gnt), 32'h20);
        check("regrant_gap", 32'(gap), 32'd8);

        // en dropped during a grant: the grant runs to HOLD_MAX, then the arbiter idles at slot 3.
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h04);
        check("endrop_first", 32'(gnt), 32'h04);
        run = 1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 8'h04);
            if (gnt != 8'h04) break;
            run++;
        end
        check("endrop_len", 32'(run), 32'd4);
        check("endrop_slot", 32'(slot_idx), 32'd3);
        check("endrop_phase", 32'(phase), 32'b0111);
        step(1'b0, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 8'hFF);
        check("idle_frozen_slot", 32'(slot_idx), 32'd3);
        check("idle_no_gnt", 32'(gnt), 32'h0);

        // Reset mid-grant drops the grant at once and lands in IDLE.
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h40);
        check("g6_gnt", 32'(gnt), 32'h40);
        step(1'b1, 1'b1, 8'h40);
        check("rstmid_gnt", 32'(gnt), 32'h0);
        check("rstmid_gvalid", 32'(gnt_valid), 32'h0);
        check("rstmid_phase", 32'(phase), 32'h0);
        step(1'b0, 1'b1, 8'h01);
        check("rstmid_idle", 32'(gnt), 32'h0);
        step(1'b0, 1'b1, 8'h01);
        check("rstmid_scan_gnt", 32'(gnt), 32'h01);

`ifdef JOHNSON_TDM_ILLEGAL_DET_EN
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        force dut.u_phase.js = 4'b0101;
        #1;
        release dut.u_phase.js;
        @(negedge clk);
        check("illegal_pulse", 32'(illegal), 32'h1);
        check("illegal_phase", 32'(phase), 32'h0);
        step(1'b0, 1'b1, 8'h00);
        check("illegal_clear", 32'(illegal), 32'h0);
        check("illegal_resume", 32'(phase), 32'b0001);
`else
        check("illegal_tied", 32'(illegal), 32'h0);
`endif

        // Random traffic against the reference model.
        step(1'b1, 1'b0, 8'h00);
        model_step(1'b1, 1'b0, 8'h00);
        qq = '0;
        for (int i = 0; i < 1500; i++) begin
            rr = ($urandom_range(0, 99) < 2);
            ee = ($urandom_range(0, 99) < 90);
            if ($urandom_range(0, 3) == 0) qq = S'($urandom & $urandom);
            step(rr, ee, qq);
            model_step(rr, ee, qq);
            check("rnd_slot",    32'(slot_idx),  32'(m_slot));
            check("rnd_phase",   32'(phase),     32'(slot_phase(m_slot)));
            check("rnd_gnt",     32'(gnt),       32'(m_gnt));
            check("rnd_gvalid",  32'(gnt_valid), 32'(m_gnt != '0));
            check("rnd_wrap",    32'(wrap),      32'(m_wrap));
            check("rnd_illegal", 32'(illegal),   32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
